// File: rtl/token_pkg.sv
// Shared token values, state encoding and default widths for the token sequence transmitter.
package token_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned GAP_W_DEF = 3;

  localparam logic [1:0] TOK_IDLE = 2'b00;
  localparam logic [1:0] TOK_A    = 2'b01;
  localparam logic [1:0] TOK_B    = 2'b10;
  localparam logic [1:0] TOK_C    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_GAP  = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  // Token driven on the bus while sitting in a given state.
  function automatic logic [1:0] tok_of(input state_e s);
    case (s)
      ST_T1:   tok_of = TOK_A;
      ST_T2:   tok_of = TOK_B;
      ST_T3:   tok_of = TOK_C;
      default: tok_of = TOK_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter timing the idle gap between frames; expired_c flags the last gap cycle.
module gap_timer #(
  parameter int unsigned GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [GAP_W-1:0] load_val,
  output logic             expired_c
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  // A count of one means this is the final 00 cycle of the gap.
  assign expired_c = (cnt <= GAP_W'(1));

endmodule

// File: rtl/token_seq_tx.sv
// Frame generator emitting 01,10,11 token frames separated by programmable 00 gaps.
// Optional TOKEN_HOLD_EN adds a hold input that parks the bus and restarts the current frame.
module token_seq_tx
  import token_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frames,
  input  logic [GAP_W-1:0] gap_len,
`ifdef TOKEN_HOLD_EN
  input  logic             hold,
`endif
  output logic [1:0]       num,
  output logic             num_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] frames_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] sent_inc;
  logic             accept, clr_cnt, inc_cnt, done_nxt, tmr_load, tmr_dec, gap_expired_c;

  assign sent_inc = sent_cnt + CNT_W'(1);
  assign tmr_dec  = (state == ST_GAP);

  gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .dec       (tmr_dec),
    .load_val  (gap_q),
    .expired_c (gap_expired_c)
  );

  // Next-state and per-transition control decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr_cnt = 1'b1;
          if (frames != '0) begin
            accept    = 1'b1;
            state_nxt = ST_T1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_T1: state_nxt = ST_T2;
      ST_T2: state_nxt = ST_T3;
      ST_T3: begin
        inc_cnt = 1'b1;
        if (sent_inc == frames_q) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (gap_q == '0) begin
          state_nxt = ST_T1;
        end else begin
          state_nxt = ST_GAP;
          tmr_load  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_expired_c) state_nxt = ST_T1;
      end
`ifdef TOKEN_HOLD_EN
      ST_HOLD: begin
        if (!hold) state_nxt = ST_T1;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
`ifdef TOKEN_HOLD_EN
    // Hold overrides everything in an active state; the partial frame is dropped uncounted.
    if (hold && (state inside {ST_T1, ST_T2, ST_T3, ST_GAP})) begin
      state_nxt = ST_HOLD;
      inc_cnt   = 1'b0;
      done_nxt  = 1'b0;
      tmr_load  = 1'b0;
    end
`endif
  end

  // State, latched request and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      frames_q <= '0;
      gap_q    <= '0;
      sent_cnt <= '0;
      num      <= TOK_IDLE;
      num_vld  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      num     <= tok_of(state_nxt);
      num_vld <= (state_nxt inside {ST_T1, ST_T2, ST_T3});
      busy    <= (state_nxt != ST_IDLE);
      done    <= done_nxt;
      if (accept) begin
        frames_q <= frames;
        gap_q    <= gap_len;
      end
      if (clr_cnt) begin
        sent_cnt <= '0;
      end else if (inc_cnt) begin
        sent_cnt <= sent_inc;
      end
    end
  end

endmodule

// File: tb/tb_token_seq_tx.sv
// Scoreboard bench for token_seq_tx: expected token streams are queued per request and checked by a monitor.
module tb_token_seq_tx;
  import token_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] frames;
  logic [GAP_W-1:0] gap_len;
`ifdef TOKEN_HOLD_EN
  logic             hold;
`endif
  logic [1:0]       num;
  logic             num_vld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  logic [1:0]       tok_q[$];
  logic [CNT_W-1:0] done_q[$];

  token_seq_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .frames   (frames),
    .gap_len  (gap_len),
`ifdef TOKEN_HOLD_EN
    .hold     (hold),
`endif
    .num      (num),
    .num_vld  (num_vld),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request of f frames is f copies of 01,10,11 with g zeros between them.
  task automatic push_req(input int f, input int g);
    for (int i = 0; i < f; i++) begin
      tok_q.push_back(2'b01);
      tok_q.push_back(2'b10);
      tok_q.push_back(2'b11);
      if (i < f - 1)
        for (int k = 0; k < g; k++) tok_q.push_back(2'b00);
    end
    done_q.push_back(CNT_W'(f));
  endtask

  // Monitor: every busy cycle consumes one expected token; every done pulse one expected count.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) begin
          if (tok_q.size() == 0) begin
            check("unexpected_busy", 1, 0);
          end else begin
            logic [1:0] e;
            e = tok_q.pop_front();
            check("num", int'(num), int'(e));
            check("num_vld", int'(num_vld), int'(e != 2'b00));
          end
        end else begin
          check("idle_num", int'(num), 0);
          check("idle_vld", int'(num_vld), 0);
        end
        if (done) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            logic [CNT_W-1:0] ec;
            ec = done_q.pop_front();
            check("done_sent_cnt", int'(sent_cnt), int'(ec));
            check("done_busy", int'(busy), 0);
          end
        end
      end
    end
  end

  // Issue one request; optionally inject an ignored start, a hold window, or a mid-frame reset.
  task automatic do_req(input int f, input int g, input bit noise, input bit do_hold, input bit do_rst);
    int budget;
    bit got_done;
    @(negedge clk);
    start   = 1'b1;
    frames  = CNT_W'(f);
    gap_len = GAP_W'(g);
`ifdef TOKEN_HOLD_EN
    if (do_hold && f != 0) begin
      tok_q.push_back(2'b01);
      tok_q.push_back(2'b10);
      for (int k = 0; k < 3; k++) tok_q.push_back(2'b00);
    end
`endif
    push_req(f, g);
    @(posedge clk);
    #1;
    start   = 1'b0;
    frames  = CNT_W'($urandom);
    gap_len = GAP_W'($urandom);
    budget  = f * (3 + g) + 12;
    got_done = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("start_latency_busy", int'(busy), int'(f != 0));
        check("start_latency_num", int'(num), (f != 0) ? 1 : 0);
      end
      if (noise) begin
        if (cyc == 1) begin
          start  = 1'b1;
          frames = CNT_W'(5);
        end else if (cyc == 2) begin
          start = 1'b0;
        end
      end
`ifdef TOKEN_HOLD_EN
      if (do_hold) begin
        if (cyc == 1) hold = 1'b1;
        else if (cyc == 4) hold = 1'b0;
      end
`endif
      if (do_rst && cyc == 4 + g) begin
        rst_n = 1'b0;
        #1;
        check("rst_num", int'(num), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sent_cnt", int'(sent_cnt), 0);
        check("rst_done", int'(done), 0);
        tok_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        got_done = 1'b1;
        break;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    @(negedge clk);
    if (!do_rst) check("idle_hold_sent_cnt", int'(sent_cnt), f);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    frames  = '0;
    gap_len = '0;
`ifdef TOKEN_HOLD_EN
    hold    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_num", int'(num), 0);
    check("reset_vld", int'(num_vld), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sent_cnt", int'(sent_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(1, 0, 1'b0, 1'b0, 1'b0);
    do_req(3, 2, 1'b0, 1'b0, 1'b0);
    do_req(0, 5, 1'b0, 1'b0, 1'b0);
    do_req(2, 0, 1'b1, 1'b0, 1'b0);
    do_req(15, 7, 1'b0, 1'b0, 1'b0);
    do_req(4, 1, 1'b0, 1'b0, 1'b1);
    do_req(2, 3, 1'b0, 1'b0, 1'b0);
`ifdef TOKEN_HOLD_EN
    do_req(2, 1, 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 10; i++) begin
      do_req(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("tok_q_drained", tok_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_seq_tx.md
Name: token_seq_tx

Overview:
- Transmit-side counterpart to the 2-bit token sequence detector: generates frames of tokens 01 -> 10 -> 11 on a 2-bit num bus.
- Each frame is followed by a programmable idle gap of 00 tokens.
- Emits a programmed number of frames per start request and drives the detector's num input in the datapath and on benches.
- Moore machine: all outputs decode directly from registered state.

Parameters:
- CNT_W, 4, width of frame-count request and sent-frame counter (max 2^CNT_W-1 frames).
- GAP_W, 3, width of idle-gap length (0 to 2^GAP_W-1 cycles of 00 between frames).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse, sampled only in IDLE.
- frames  input  CNT_W  number of frames to send, latched with start.
- gap_len  input  GAP_W  00-cycles between frames, latched with start.
- hold  input  1  pause request; present only with TOKEN_HOLD_EN.
- num  output  2  token bus to detector.
- num_vld  output  1  high while num carries a frame token (01/10/11).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a request completes.
- sent_cnt  output  CNT_W  frames fully sent in current/last request.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; num=00, num_vld=0, busy=0, done=0, sent_cnt=0; latched frames/gap cleared.
  - Reset mid-frame aborts immediately. No done pulse.
- States: IDLE, T1 (num=01), T2 (num=10), T3 (num=11), GAP (num=00). num_vld=1 only in T1/T2/T3.
- IDLE, start=1, frames!=0:
  - Latch frames and gap_len; sent_cnt<=0.
  - Next state T1, so the first token appears the cycle after start is sampled (latency 1).
- IDLE, start=1, frames==0:
  - Stay IDLE, no tokens; done pulses in the next cycle; sent_cnt<=0.
- start while busy is ignored. frames/gap_len changes after latching have no effect.
- T1->T2->T3 unconditionally, one cycle each.
- T3 exit:
  - sent_cnt<=sent_cnt+1.
  - If sent_cnt+1==latched frames: next IDLE, done<=1 for exactly one cycle (coincident with the first IDLE cycle).
  - Else if gap_len==0: next T1 (back-to-back frames).
  - Else: next GAP.
- GAP:
  - Down-counter loaded with gap_len on T3 exit; holds num=00 for exactly gap_len cycles, then T1.
- sent_cnt holds its value in IDLE until the next accepted start.
- No wrap-around: frames max is 2^CNT_W-1, and the terminal compare occurs before any overflow.
- State encoding: 3-bit; unused codes recover to IDLE.

Optional Feature:
- Macro: TOKEN_HOLD_EN.
- With the macro:
  - hold=1 in T1/T2/T3/GAP forces the next state to HOLD (num=00, num_vld=0, busy=1).
  - HOLD persists while hold=1. On hold=0 it returns to T1, restarting the current frame from its first token; sent_cnt is unchanged. The aborted partial frame does not count.
  - hold in IDLE is ignored.
- Without the macro: the hold port and HOLD state do not exist.

Decomposition:
- Package token_pkg:
  - Token constants TOK_IDLE=2'b00, TOK_A=2'b01, TOK_B=2'b10, TOK_C=2'b11.
  - State encoding constants for IDLE/T1/T2/T3/GAP/HOLD.
  - Default CNT_W/GAP_W.
- Sub-module gap_timer (GAP_W): load/decrement counter with expired flag, instantiated for the GAP state.

Test Plan:
- Reset release, start=1, frames=1, gap_len=0 -> num sequence 01,10,11 on three consecutive cycles starting one cycle after start; done=1 on the next cycle; sent_cnt=1, busy=0.
- frames=3, gap_len=2 -> 01,10,11,00,00,01,10,11,00,00,01,10,11, then done; num_vld low exactly on the four gap cycles; sent_cnt=3.
- frames=0 with start -> num stays 00, busy stays 0, done pulses once the next cycle.
- frames=2, gap_len=0, start re-asserted mid-transfer with frames=5 -> second request ignored; exactly 6 tokens sent; sent_cnt=2.
- rst_n pulled low during the T2 cycle of frame 2 of 4 -> num=00, busy=0, sent_cnt=0 immediately, no done pulse; a fresh start works normally.
- TOKEN_HOLD_EN: frames=2, hold=1 for 3 cycles asserted during T2 of frame 1 -> 01,10, then 00 x3, then 01,10,11, gap, 01,10,11, done; sent_cnt=2.
